// File: rtl/cmos_capture_pack_if.sv
// CMOS sensor byte stream in, packed RGB888 pixel stream out.
// The slave modport is the capture block; the master modport is the sensor/sink side.
interface cmos_capture_pack_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [23:0] cmos_frame_data;

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
  );

  modport master (
    output cmos_vsync, cmos_href, cmos_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
  );
endinterface

// File: rtl/cmos_capture_pack.sv
// Camera capture front end: skips the first frames after sensor config, packs gray8/RGB565/RGB888
// bytes into RGB888 pixels and flags line-length and frame-height errors.
module cmos_capture_pack #(
  parameter int unsigned IMG_W       = 1280,
  parameter int unsigned IMG_H       = 720,
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             cmos_pclk,
  input  logic             sys_rst,
  input  logic             cmos_cfg_done,
  input  logic [1:0]       fmt,
  cmos_capture_pack_if.slave cam,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             line_err,
  output logic             frame_err
);

  localparam int unsigned SkipW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SkipW-1:0] SkipMax = SkipW'(SKIP_FRAMES);
  localparam logic [CNT_W-1:0] ImgW = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] ImgH = CNT_W'(IMG_H);

  logic             s1_vsync_q, s1_href_q, s2_vsync_q, s2_href_q;
  logic [7:0]       s1_data_q, b0_q, b1_q;
  logic             armed_q, in_frame_q, frame_en_q;
  logic [SkipW-1:0] skip_q;
  logic [1:0]       fmt_lat_q, phase_q;
  logic             fv_q, fh_q, valid_q;
  logic [23:0]      data_q;
  logic [CNT_W-1:0] pix_cnt_q, line_cnt_q;
  logic             line_err_q, frame_err_q;

  logic             frame_start, frame_end, line_start, line_end, byte_vld, pix_done;
  logic             frame_en_d, bad_line;
  logic [1:0]       last_phase, cur_phase, phase_d;
  logic [4:0]       r5, c5;
  logic [5:0]       g6;
  logic [23:0]      pix;
  logic [CNT_W-1:0] line_cnt_nxt;

  always_comb begin
    // armed_q suppresses the bogus vsync edge seen when reset releases mid-frame
    frame_start  = s1_vsync_q & ~s2_vsync_q & armed_q;
    frame_end    = ~s1_vsync_q & s2_vsync_q & in_frame_q;
    line_start   = s1_href_q & ~s2_href_q;
    line_end     = ~s1_href_q & s2_href_q;
    byte_vld     = s1_href_q & s1_vsync_q;
    last_phase   = 2'd0;
    unique case (fmt_lat_q)
      2'd1:    last_phase = 2'd1;
      2'd2:    last_phase = 2'd2;
      default: last_phase = 2'd0;
    endcase
    cur_phase    = line_start ? 2'd0 : phase_q;
    pix_done     = byte_vld & (cur_phase == last_phase);
    phase_d      = byte_vld ? (pix_done ? 2'd0 : 2'(cur_phase + 2'd1)) : 2'd0;
    frame_en_d   = frame_start ? (cmos_cfg_done & (skip_q == SkipMax)) : frame_en_q;
    line_cnt_nxt = line_cnt_q + CNT_W'(line_end);
    bad_line     = (line_end & ((pix_cnt_q != ImgW) | (phase_q != 2'd0)))
                 | (s1_href_q & ~s1_vsync_q);

    r5  = b0_q[7:3];
    g6  = {b0_q[2:0], s1_data_q[7:5]};
    c5  = s1_data_q[4:0];
    pix = {3{s1_data_q}};
    unique case (fmt_lat_q)
      2'd1:    pix = {r5, r5[4:2], g6, g6[5:4], c5, c5[4:2]};
      2'd2:    pix = {b0_q, b1_q, s1_data_q};
      default: pix = {3{s1_data_q}};
    endcase
  end

  always_ff @(posedge cmos_pclk) begin
    if (sys_rst) begin
      s1_vsync_q  <= 1'b0;
      s1_href_q   <= 1'b0;
      s2_vsync_q  <= 1'b0;
      s2_href_q   <= 1'b0;
      s1_data_q   <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      armed_q     <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_en_q  <= 1'b0;
      skip_q      <= '0;
      fmt_lat_q   <= 2'd0;
      phase_q     <= 2'd0;
      fv_q        <= 1'b0;
      fh_q        <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_vsync_q <= cam.cmos_vsync;
      s1_href_q  <= cam.cmos_href;
      s1_data_q  <= cam.cmos_data;
      s2_vsync_q <= s1_vsync_q;
      s2_href_q  <= s1_href_q;
      armed_q    <= armed_q | ~cam.cmos_vsync;
      if (frame_start)    in_frame_q <= 1'b1;
      else if (frame_end) in_frame_q <= 1'b0;

      if (!cmos_cfg_done)                       skip_q <= '0;
      else if (frame_start && skip_q != SkipMax) skip_q <= skip_q + 1'b1;
      frame_en_q <= frame_en_d;
      if (frame_start) fmt_lat_q <= (fmt == 2'd3) ? 2'd0 : fmt;

      phase_q <= phase_d;
      if (byte_vld && cur_phase == 2'd0) b0_q <= s1_data_q;
      if (byte_vld && cur_phase == 2'd1) b1_q <= s1_data_q;

      fv_q    <= s1_vsync_q & frame_en_d;
      fh_q    <= s1_href_q & frame_en_d;
      valid_q <= pix_done & frame_en_q;
      if (pix_done && frame_en_q) data_q <= pix;

      pix_cnt_q   <= (line_start ? '0 : pix_cnt_q) + CNT_W'(pix_done);
      line_cnt_q  <= frame_start ? '0 : line_cnt_nxt;
      line_err_q  <= (line_err_q & ~frame_start) | bad_line;
      frame_err_q <= (frame_err_q & ~frame_start) | (frame_end & (line_cnt_nxt != ImgH));
    end
  end

  assign cam.cmos_frame_vsync = fv_q;
  assign cam.cmos_frame_href  = fh_q;
  assign cam.cmos_frame_valid = valid_q;
  assign cam.cmos_frame_data  = data_q;
  assign pix_cnt              = pix_cnt_q;
  assign line_cnt             = line_cnt_q;
  assign line_err             = line_err_q;
  assign frame_err            = frame_err_q;

endmodule

// File: tb/tb_cmos_capture_pack.sv
// Randomised bench for cmos_capture_pack: frame-level reference model feeds a scoreboard queue
// of expected pixels (data and arrival cycle) that an independent monitor drains.
module tb_cmos_capture_pack;
  localparam int W = 4;
  localparam int H = 2;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic [11:0] pix_cnt, line_cnt;
  logic        line_err, frame_err;

  cmos_capture_pack_if cam ();

  cmos_capture_pack #(
    .IMG_W(W), .IMG_H(H), .SKIP_FRAMES(SKIP), .CNT_W(12)
  ) dut (
    .cmos_pclk    (clk),
    .sys_rst      (rst),
    .cmos_cfg_done(cfg),
    .fmt          (fmt),
    .cam          (cam),
    .pix_cnt      (pix_cnt),
    .line_cnt     (line_cnt),
    .line_err     (line_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;
  exp_t expq[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int   fs = 0;
  bit   en_m = 0;
  int   fmt_m = 0, bpp_m = 1, lines_m = 0;
  bit   lerr_m = 0, ferr_m = 0;
  logic [7:0] line_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_pack(input int f, input int b0, input int b1, input int b2);
    int r5, g6, c5;
    case (f)
      1: begin
        r5 = b0 >> 3;
        g6 = ((b0 & 7) << 3) | (b1 >> 5);
        c5 = b1 & 31;
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((c5 << 3) | (c5 >> 2))};
      end
      2: return {8'(b0), 8'(b1), 8'(b2)};
      default: return {8'(b0), 8'(b0), 8'(b0)};
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (cam.cmos_frame_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_valid", 32'(cam.cmos_frame_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check("pix_data", 32'(cam.cmos_frame_data), 32'(e.data));
        check("pix_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input bit v);
    cfg = v;
    if (!v) fs = 0;
  endtask

  task automatic fill_rand(input int n);
    line_bytes.delete();
    for (int i = 0; i < n; i++) line_bytes.push_back(8'($urandom));
  endtask

  task automatic start_frame();
    cam.cmos_vsync = 1'b1;
    en_m = cfg && (fs >= SKIP);
    if (cfg) fs = (fs < SKIP) ? fs + 1 : fs;
    else fs = 0;
    fmt_m   = (fmt == 2'd3) ? 0 : int'(fmt);
    bpp_m   = fmt_m + 1;
    lines_m = 0;
    lerr_m  = 0;
    ferr_m  = 0;
    repeat (3) tick();
    check("frame_vsync_on", 32'(cam.cmos_frame_vsync), 32'(en_m));
    check("line_cnt_clr", 32'(line_cnt), 32'd0);
    check("line_err_clr", 32'(line_err), 32'd0);
    check("frame_err_clr", 32'(frame_err), 32'd0);
  endtask

  task automatic send_line();
    int n, j, npix;
    n = line_bytes.size();
    for (int i = 0; i < n; i++) begin
      if (i == 2) check("frame_href", 32'(cam.cmos_frame_href), 32'(en_m));
      cam.cmos_href = 1'b1;
      cam.cmos_data = line_bytes[i];
      if (((i + 1) % bpp_m) == 0 && en_m) begin
        j = i + 1 - bpp_m;
        expq.push_back('{ref_pack(fmt_m, line_bytes[j], (bpp_m > 1) ? line_bytes[j+1] : 0,
                                  (bpp_m > 2) ? line_bytes[j+2] : 0), cyc + 2});
      end
      tick();
    end
    cam.cmos_href = 1'b0;
    cam.cmos_data = 8'h00;
    repeat (4) tick();
    npix = n / bpp_m;
    lines_m++;
    if (npix != W || (n % bpp_m) != 0) lerr_m = 1;
    check("pix_cnt", 32'(pix_cnt), npix);
    check("line_err", 32'(line_err), 32'(lerr_m));
    check("line_cnt", 32'(line_cnt), lines_m);
  endtask

  task automatic end_frame();
    cam.cmos_vsync = 1'b0;
    repeat (3) tick();
    ferr_m = (lines_m != H);
    check("frame_err", 32'(frame_err), 32'(ferr_m));
    check("line_cnt_end", 32'(line_cnt), lines_m);
    check("frame_vsync_off", 32'(cam.cmos_frame_vsync), 32'd0);
    repeat (2) tick();
  endtask

  task automatic simple_frame(input int nl, input int nb);
    start_frame();
    for (int l = 0; l < nl; l++) begin
      fill_rand(nb);
      send_line();
    end
    end_frame();
  endtask

  initial begin
    cam.cmos_vsync = 1'b0;
    cam.cmos_href  = 1'b0;
    cam.cmos_data  = 8'h00;
    repeat (4) tick();
    check("rst_valid", 32'(cam.cmos_frame_valid), 32'd0);
    check("rst_data", 32'(cam.cmos_frame_data), 32'd0);
    check("rst_vsync", 32'(cam.cmos_frame_vsync), 32'd0);
    check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    rst = 1'b0;
    tick();
    set_cfg(1'b1);
    tick();

    // Skip two frames, then two enabled gray frames
    for (int f = 0; f < 4; f++) simple_frame(H, W);

    // RGB565 known bytes, short line then full line
    fmt = 2'd1;
    start_frame();
    line_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line();
    fill_rand(8);
    send_line();
    end_frame();

    // RGB888 then fmt change mid-frame
    fmt = 2'd2;
    start_frame();
    line_bytes = '{8'h12, 8'h34, 8'h56};
    send_line();
    fmt = 2'd0;
    fill_rand(12);
    send_line();
    end_frame();
    simple_frame(H, W);

    // 5-byte RGB565 line: 2 pixels, partial discarded
    fmt = 2'd1;
    start_frame();
    fill_rand(5);
    send_line();
    fill_rand(8);
    send_line();
    end_frame();

    // Three-line frame, then reserved format
    fmt = 2'd0;
    simple_frame(3, W);
    fmt = 2'd3;
    simple_frame(H, W);

    // Random formats and line lengths
    for (int f = 0; f < 6; f++) begin
      fmt = 2'($urandom_range(0, 3));
      start_frame();
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        if ($urandom_range(0, 1) == 1) fill_rand(bpp_m * W);
        else fill_rand(int'($urandom_range(bpp_m * W - 2, bpp_m * W + 2)));
        send_line();
      end
      end_frame();
    end

    // cfg_done low restarts skipping; a mid-frame drop keeps the frame enabled
    fmt = 2'd0;
    set_cfg(1'b0);
    simple_frame(H, W);
    set_cfg(1'b1);
    for (int f = 0; f < 3; f++) simple_frame(H, W);
    start_frame();
    fill_rand(W);
    send_line();
    set_cfg(1'b0);
    fill_rand(W);
    send_line();
    end_frame();
    set_cfg(1'b1);
    for (int f = 0; f < 3; f++) simple_frame(H, W);

    // Reset mid-line in an enabled frame
    start_frame();
    cam.cmos_href = 1'b1;
    cam.cmos_data = 8'hA5;
    expq.push_back('{24'hA5A5A5, cyc + 2});
    tick();
    cam.cmos_data = 8'h5A;
    tick();
    rst = 1'b1;
    cam.cmos_data = 8'h33;
    tick();
    rst = 1'b0;
    fs = 0;
    en_m = 0;
    check("mid_rst_valid", 32'(cam.cmos_frame_valid), 32'd0);
    check("mid_rst_vsync", 32'(cam.cmos_frame_vsync), 32'd0);
    check("mid_rst_href", 32'(cam.cmos_frame_href), 32'd0);
    check("mid_rst_data", 32'(cam.cmos_frame_data), 32'd0);
    check("mid_rst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("mid_rst_line_cnt", 32'(line_cnt), 32'd0);
    check("mid_rst_errs", 32'({line_err, frame_err}), 32'd0);
    repeat (3) tick();
    cam.cmos_href = 1'b0;
    repeat (3) tick();
    cam.cmos_vsync = 1'b0;
    repeat (4) tick();
    for (int f = 0; f < 3; f++) simple_frame(H, W);

    repeat (20) tick();
    check("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not reach the end, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
